led_bank_arbiter: RTL
=====================

Name: led_bank_arbiter

Overview:
- Shares the on-board LED bank between NUM_REQ pattern sources.
- Uses round-robin arbitration with a fixed dwell time per grant.
- Dwell time is measured in prescaled ticks of the 27 MHz board clock.
- Sits between the pattern/counter generators and the top-level LED pins.
- Drives the pins active-low, so logic 1 in a pattern means LED lit.

Parameters:
- CLK_DIV, 13500000: clk cycles per tick (0.5 s at 27 MHz). Minimum 2.
- DWELL_TICKS, 4: ticks a grant is held before re-arbitration. Minimum 1.
- NUM_REQ, 3: number of requesters. Minimum 2.
- LED_W, 6: LED bank width.

Ports:
- clk  in  1  board clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-source request, level-sensitive.
- pat  in  NUM_REQ*LED_W  patterns; source i occupies bits [i*LED_W +: LED_W]; 1 = lit.
- grant  out  NUM_REQ  one-hot current owner; all zero when no owner.
- led  out  LED_W  pin drive, active-low; all ones = all off.
- tick  out  1  one-cycle pulse at each prescaler terminal count.
- busy  out  1  high while in HOLD.

Behaviour:
- Reset (asynchronous, takes effect immediately regardless of state):
  - state = IDLE; led = all ones; grant = 0; busy = 0; tick = 0.
  - prescaler = 0; dwell = 0; ptr = NUM_REQ-1, so the first search starts at source 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick = 1 in the cycle where count == CLK_DIV-1.
  - Cleared to 0 in the cycle HOLD is entered; free-runs in every other state.
  - Width is $clog2(CLK_DIV); no other wrap behaviour.
- All outputs are registered.
- FSM states: IDLE, ARB, HOLD.
- IDLE:
  - led = all ones; grant = 0.
  - Goes to ARB when any req bit is set.
- ARB (exactly one cycle):
  - led = all ones; grant = 0.
  - Winner = first set req bit searching cyclically from ptr+1.
  - If no req bit is set (all dropped), return to IDLE.
  - Otherwise go to HOLD and, on the same edge:
    - load grant = onehot(winner);
    - load ptr = winner;
    - load led = ~pat slice of winner;
    - clear dwell and prescaler.
- HOLD:
  - busy = 1.
  - Each cycle led <= ~pat slice of winner, giving 1-cycle latency from pat to led.
  - dwell increments on tick.
- HOLD exit conditions (checked in priority order):
  - (a) req[winner] == 0: next cycle grant = 0, led = all ones. Go to ARB if any req is set, else IDLE.
  - (b) tick && dwell == DWELL_TICKS-1: same outputs as (a), and the same next-state rule (ARB if any req set, else IDLE).
  - HOLD length without an early drop is exactly DWELL_TICKS*CLK_DIV cycles.
- Latency: req rising in IDLE → ARB on the next edge → grant/led valid on the following edge (2 cycles).
- Minimum gap between grants is 1 ARB cycle with LEDs off. A sole requester is re-granted after that gap.
- Simultaneous events:
  - (a) and (b) in the same cycle: treated as (a).
  - req changes during ARB: ARB samples req in that cycle only.
- pat of non-granted sources is ignored.
- grant is always one-hot or zero.

Optional Feature:
- Macro: LED_ARB_PREEMPT_EN.
- Defined:
  - In HOLD with winner != 0, req[0] == 1 forces exit to ARB on the next edge: grant = 0, led = all ones.
  - In ARB, req[0] wins unconditionally, regardless of ptr.
  - ptr is still updated to the winner.
- Undefined: pure round-robin; req[0] has no special priority; HOLD exits only per (a)/(b).

Test Plan:
Bench parameters for all cases: CLK_DIV=4, DWELL_TICKS=2, NUM_REQ=3, LED_W=6.
1. Assert rst, hold 3 cycles; release with req=0 → led=6'b111111, grant=3'b000, busy=0, state IDLE; tick pulses every 4th cycle.
2. req=3'b010, pat1=6'b000101 → grant=3'b010 and led=6'b111010 two cycles after req. Both hold 8 cycles, then 1 cycle grant=0/led=6'b111111, then re-grant to 3'b010.
3. req=3'b111 held steady → grant sequence 001, 010, 100, 001. Each grant lasts 8 cycles, separated by 1-cycle gaps; led tracks the matching pat.
4. Source 2 granted, req[2] dropped at HOLD cycle 3 → next cycle grant=0, led=6'b111111. Goes to ARB if others are requesting, else IDLE. A pat2 change mid-HOLD appears on led 1 cycle later.
5. Assert rst asynchronously mid-HOLD (not on a clk edge) → led=6'b111111, grant=0, busy=0 immediately. After release with req=3'b111, the first grant is 3'b001.
6. With LED_ARB_PREEMPT_EN defined: source 1 holding, req[0] rises → grant=0 next cycle, then grant=3'b001. Without the macro, source 1 keeps its full 8 cycles.

Source files
------------

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin sharing of the active-low LED bank with a fixed dwell per grant.
// Optional feature macro: LED_ARB_PREEMPT_EN (source 0 preempts other owners and wins every arbitration).
module led_bank_arbiter #(
  parameter int CLK_DIV     = 13500000,
  parameter int DWELL_TICKS = 4,
  parameter int NUM_REQ     = 3,
  parameter int LED_W       = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] pat,
  output logic [NUM_REQ-1:0]       grant,
  output logic [LED_W-1:0]         led,
  output logic                     tick,
  output logic                     busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CW-1:0]      CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0]      DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [PW-1:0]      PTR_INIT   = PW'(NUM_REQ - 1);
  localparam logic [LED_W-1:0]   LED_OFF    = {LED_W{1'b1}};
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;

  logic [CW-1:0]      cnt_run_s;
  logic [PW-1:0]      win_s;
  logic               any_req_s;
  logic               hold_exit_s;

  // First set request after position p, wrapping cyclically.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [PW-1:0]      p);
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    pick = p;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx  = PW'((int'(p) + k) % NUM_REQ);
      pick = r[idx] ? idx : pick;
    end
    return pick;
  endfunction

  function automatic logic [LED_W-1:0] pat_slice(input logic [NUM_REQ*LED_W-1:0] v,
                                                 input logic [PW-1:0]            s);
    logic [LED_W-1:0] res;
    res = {LED_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      res = (PW'(i) == s) ? LED_W'(v >> (i * LED_W)) : res;
    end
    return res;
  endfunction

  // Next-state, prescaler, dwell and output computation.
  always_comb begin
    state_d     = state_q;
    cnt_run_s   = (cnt_q == CNT_LAST) ? {CW{1'b0}} : cnt_q + CW'(1'b1);
    cnt_d       = cnt_run_s;
    dwell_d     = dwell_q;
    ptr_d       = ptr_q;
    grant_d     = {NUM_REQ{1'b0}};
    led_d       = LED_OFF;
    any_req_s   = |req;
    hold_exit_s = 1'b0;
`ifdef LED_ARB_PREEMPT_EN
    win_s = req[0] ? {PW{1'b0}} : rr_pick(req, ptr_q);
`else
    win_s = rr_pick(req, ptr_q);
`endif

    case (state_q)
      IDLE: begin
        state_d = any_req_s ? ARB : IDLE;
      end
      ARB: begin
        if (any_req_s) begin
          state_d = HOLD;
          grant_d = ONE_HOT0 << win_s;
          ptr_d   = win_s;
          led_d   = ~pat_slice(pat, win_s);
          dwell_d = {DW{1'b0}};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        // A dropped request and dwell expiry both release the bank the same way.
        hold_exit_s = !req[ptr_q] || (tick_q && (dwell_q == DWELL_LAST));
`ifdef LED_ARB_PREEMPT_EN
        hold_exit_s = hold_exit_s || ((ptr_q != {PW{1'b0}}) && req[0]);
`endif
        if (hold_exit_s) begin
          state_d = any_req_s ? ARB : IDLE;
        end else begin
          grant_d = grant_q;
          led_d   = ~pat_slice(pat, ptr_q);
          dwell_d = tick_q ? dwell_q + DW'(1'b1) : dwell_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tick_d = (cnt_d == CNT_LAST);
    busy_d = (state_d == HOLD);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      dwell_q <= {DW{1'b0}};
      ptr_q   <= PTR_INIT;
      grant_q <= {NUM_REQ{1'b0}};
      led_q   <= LED_OFF;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign led   = led_q;
  assign tick  = tick_q;
  assign busy  = busy_q;

endmodule
